copy_packet_to_memory: RTL and testbench
========================================

Name: copy_packet_to_memory

Overview:
- Receive-side packet buffer behind the Ethernet frame analyzer.
- Stores the data bytes of each received frame in a circular byte RAM and pushes the frame length into a length FIFO on a good frame end.
- Rolls back bad frames so they are never seen downstream.
- Lets the consumer read stored packets byte by byte, with per-packet length and last-byte marking.

Parameters:
- pDATA_WIDTH, 8, byte width of RX and read data.
- pMIN_PACKET_LENGHT, 64, minimum accepted frame length in bytes.
- pMAX_PACKET_LENGHT, 1536, maximum accepted frame length in bytes.
- pFIFO_WIDTH, 11, width of a length FIFO entry and of olen_pac.
- pDEPTH_RAM, 2048, packet RAM depth in bytes (power of 2).
- pFIFO_DEPTH, 16, length FIFO depth (power of 2).

Ports:
- iclk in 1: single clock, all logic on rising edge.
- i_rst in 1: reset, asynchronous, active-high.
- idv in 1: RX data valid.
- irx_d in pDATA_WIDTH: RX byte.
- irx_er in 1: RX error.
- iframe_state in 3: analyzer state, encoded as follows.
  - 0 IDLE, 1 PREAMBLE, 2 SFD, 3 DATA, 4 END_OK, 5 END_ERR.
  - 6 and 7 are treated as IDLE.
- ird_en in 1: read enable.
- oempty out 1: no committed bytes in RAM.
- ofull out 1: free RAM < pMAX_PACKET_LENGHT, or length FIFO full.
- or_data out pDATA_WIDTH: read byte.
- olen_pac out pFIFO_WIDTH: length of packet at FIFO head; 0 when ofifo_em.
- onext_last out 1: or_data holds the last byte of its packet.
- obytes_to_read out $clog2(pDEPTH_RAM)+1 (12): committed, unread bytes.
- ofifo_em out 1: length FIFO empty.
- ofifo_full out 1: length FIFO full.

Behaviour:
- Reset values: all outputs 0 except oempty=1 and ofifo_em=1. Pointers, counters and the FIFO are cleared.
- Write side uses two pointers, wr_ptr (speculative) and commit_ptr.
  - Entering DATA from a non-DATA state latches accept = !ofull. The packet byte counter is cleared.
  - Each cycle with idv=1 and state=DATA: if accept, write irx_d to RAM[wr_ptr], then increment wr_ptr and the counter.
  - irx_er=1 during DATA sets a sticky err flag.
  - The counter saturates at pMAX_PACKET_LENGHT+1; writes stop there and the frame is marked oversize.
- Frame end (first cycle of END_OK or END_ERR):
  - Commit only if all hold: END_OK, accept, !err, counter within [min,max], FIFO not full.
  - On commit: push the counter to the length FIFO and set commit_ptr=wr_ptr.
  - Otherwise rewind wr_ptr=commit_ptr.
  - In both cases clear err.
  - Leaving DATA into IDLE/PREAMBLE without an END state is handled as END_ERR.
- obytes_to_read increases by the committed length one cycle after commit. It decreases by 1 per read byte.
  - A simultaneous commit and read applies both.
- Read side:
  - ird_en=1 with !oempty reads RAM[rd_ptr] into or_data with 1-cycle latency, then increments rd_ptr.
  - ird_en with oempty is ignored and or_data holds its value.
  - A per-packet read counter is compared against olen_pac. On the last byte, onext_last=1 in the same cycle or_data shows it (one-cycle pulse per packet).
  - The length FIFO pops at that point and the counter clears.
  - Continuous ird_en streams across packet boundaries without bubbles.
- Pointers wrap modulo pDEPTH_RAM.
- Uncommitted bytes are never readable.
- Reset mid-frame or mid-read discards everything.

Optional Feature:
- Macro: COPY_PACKET_STRIP_FCS_EN.
- When defined:
  - Min/max checks use the received length.
  - Committed length is the received length − 4 and commit_ptr = wr_ptr − 4, so the FCS is dropped.
- When undefined: full frame including FCS is stored.

Decomposition:
- Package copy_packet_pkg holds:
  - the frame-state enum (IDLE..END_ERR, 3 bits),
  - default length/depth constants,
  - the FCS length constant 4.
- One natural sub-module: sync_fifo (length FIFO, show-ahead, with empty/full flags).
- The byte RAM is inferred inline.

Test Plan:
- 64-byte good frame (DATA×64 then END_OK), no reads:
  - olen_pac=64, obytes_to_read=64, ofifo_em=0, oempty=0.
- Read that frame with ird_en held:
  - 64 bytes in order, 1-cycle latency.
  - onext_last pulses with byte 64.
  - Then oempty=1, ofifo_em=1, obytes_to_read=0.
- 64-byte frame with irx_er at byte 10:
  - Nothing committed, obytes_to_read stays 0.
  - A following good 100-byte frame reads back correctly.
- 40-byte frame, and a 1600-byte frame:
  - Both dropped; the write pointer is restored.
- Back-to-back frames of 64 and 70 bytes, then a continuous read:
  - onext_last pulses after bytes 64 and 134.
  - olen_pac shows 64 then 70.
- Fill until free space < 1536:
  - ofull=1; the next frame is dropped entirely.
  - After reading one packet, ofull=0 and the next frame is accepted.

Source files
------------

// File: rtl/copy_packet_pkg.sv
// copy_packet_pkg: shared types and defaults for the RX packet buffer.
// Holds the analyzer frame-state encoding and the FCS length.
package copy_packet_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SFD      = 3'd2,
      ST_DATA     = 3'd3,
      ST_END_OK   = 3'd4,
      ST_END_ERR  = 3'd5
   } frame_state_e;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_MIN_LEN     = 64;
   localparam int DEF_MAX_LEN     = 1536;
   localparam int DEF_FIFO_WIDTH  = 11;
   localparam int DEF_DEPTH_RAM   = 2048;
   localparam int DEF_FIFO_DEPTH  = 16;
   localparam int FCS_LEN         = 4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO holding committed packet lengths.
// Head entry is visible on o_data whenever o_empty is low.
module sync_fifo #(
   parameter int pWIDTH = 11,
   parameter int pDEPTH = 16
) (
   input  logic              iclk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic [pWIDTH-1:0] i_data,
   input  logic              i_pop,
   output logic [pWIDTH-1:0] o_data,
   output logic              o_empty,
   output logic              o_full
);

   localparam int AW = $clog2(pDEPTH);
   localparam logic [AW:0] PONE = {{AW{1'b0}}, 1'b1};

   logic [pWIDTH-1:0] r_mem [pDEPTH];
   logic [AW:0]       r_wr;
   logic [AW:0]       r_rd;
   logic              w_push;
   logic              w_pop;

   assign o_empty = (r_wr == r_rd);
   assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd[AW-1:0]];

   // pointer update; extra MSB separates full from empty
   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + PONE;
         if (w_pop)  r_rd <= r_rd + PONE;
      end
   end

   // storage write, no reset so it maps to distributed RAM
   always_ff @(posedge iclk) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/copy_packet_to_memory.sv
// copy_packet_to_memory: circular byte RAM with commit/rollback per frame.
// Optional FCS stripping: define COPY_PACKET_STRIP_FCS_EN.
module copy_packet_to_memory
   import copy_packet_pkg::*;
#(
   parameter int pDATA_WIDTH        = DEF_DATA_WIDTH,
   parameter int pMIN_PACKET_LENGHT = DEF_MIN_LEN,
   parameter int pMAX_PACKET_LENGHT = DEF_MAX_LEN,
   parameter int pFIFO_WIDTH        = DEF_FIFO_WIDTH,
   parameter int pDEPTH_RAM         = DEF_DEPTH_RAM,
   parameter int pFIFO_DEPTH        = DEF_FIFO_DEPTH
) (
   input  logic                          iclk,
   input  logic                          i_rst,
   input  logic                          idv,
   input  logic [pDATA_WIDTH-1:0]        irx_d,
   input  logic                          irx_er,
   input  logic [2:0]                    iframe_state,
   input  logic                          ird_en,
   output logic                          oempty,
   output logic                          ofull,
   output logic [pDATA_WIDTH-1:0]        or_data,
   output logic [pFIFO_WIDTH-1:0]        olen_pac,
   output logic                          onext_last,
   output logic [$clog2(pDEPTH_RAM):0]   obytes_to_read,
   output logic                          ofifo_em,
   output logic                          ofifo_full
);

   localparam int AW = $clog2(pDEPTH_RAM);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(pMAX_PACKET_LENGHT + 2);
   localparam int FW = pFIFO_WIDTH;

   localparam logic [CW-1:0] MIN_C   = CW'(pMIN_PACKET_LENGHT);
   localparam logic [CW-1:0] MAX_C   = CW'(pMAX_PACKET_LENGHT);
   localparam logic [CW-1:0] CONE    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] PONE    = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [FW-1:0] FONE    = {{(FW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] DEPTH_C = PW'(pDEPTH_RAM);
   localparam logic [PW-1:0] MAXP_C  = PW'(pMAX_PACKET_LENGHT);

   logic [pDATA_WIDTH-1:0] r_ram [pDEPTH_RAM];

   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_commit_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [CW-1:0]          r_cnt;
   logic                   r_in_frame;
   logic                   r_accept;
   logic                   r_err;
   logic                   r_pend;
   logic [PW-1:0]          r_pend_len;
   logic [PW-1:0]          r_bytes;
   logic [FW-1:0]          r_rd_cnt;
   logic                   r_last;
   logic                   r_rd_valid;
   logic [pDATA_WIDTH-1:0] r_rd_q;

   logic                   w_in_data;
   logic                   w_start;
   logic                   w_end;
   logic [PW-1:0]          w_used;
   logic [PW-1:0]          w_free;
   logic                   w_accept;
   logic [CW-1:0]          w_cnt_base;
   logic                   w_cnt_inc;
   logic                   w_wr_en;
   logic                   w_len_ok;
   logic                   w_commit;
   logic [CW-1:0]          w_commit_len;
   logic [PW-1:0]          w_commit_wp;
   logic                   w_rd_fire;
   logic                   w_rd_last;
   logic [FW-1:0]          w_fifo_q;
   logic                   w_fifo_em;
   logic                   w_fifo_full;

   // frame boundaries seen from the analyzer state
   assign w_in_data  = (iframe_state == ST_DATA);
   assign w_start    = w_in_data && !r_in_frame;
   assign w_end      = r_in_frame && !w_in_data;

   // free space counts speculative bytes of the frame in flight
   assign w_used     = r_wr_ptr - r_rd_ptr;
   assign w_free     = DEPTH_C - w_used;
   assign ofull      = (w_free < MAXP_C) || w_fifo_full;

   assign w_accept   = w_start ? !ofull : r_accept;
   assign w_cnt_base = w_start ? '0 : r_cnt;
   assign w_cnt_inc  = w_in_data && idv && w_accept &&
                       (w_cnt_base <= MAX_C);
   assign w_wr_en    = w_cnt_inc && (w_cnt_base < MAX_C);

   assign w_len_ok   = (r_cnt >= MIN_C) && (r_cnt <= MAX_C);
   assign w_commit   = w_end && (iframe_state == ST_END_OK) &&
                       r_accept && !r_err && w_len_ok && !w_fifo_full;

`ifdef COPY_PACKET_STRIP_FCS_EN
   localparam logic [CW-1:0] FCS_C = CW'(FCS_LEN);
   localparam logic [PW-1:0] FCS_P = PW'(FCS_LEN);
   assign w_commit_len = r_cnt - FCS_C;
   assign w_commit_wp  = r_wr_ptr - FCS_P;
`else
   assign w_commit_len = r_cnt;
   assign w_commit_wp  = r_wr_ptr;
`endif

   assign oempty         = (r_bytes == '0);
   assign w_rd_fire      = ird_en && !oempty;
   assign w_rd_last      = ((r_rd_cnt + FONE) == w_fifo_q);
   assign obytes_to_read = r_bytes;
   assign onext_last     = r_last;
   assign or_data        = r_rd_valid ? r_rd_q : '0;
   assign olen_pac       = w_fifo_em ? '0 : w_fifo_q;
   assign ofifo_em       = w_fifo_em;
   assign ofifo_full     = w_fifo_full;

   sync_fifo #(
      .pWIDTH (FW),
      .pDEPTH (pFIFO_DEPTH)
   ) u_len_fifo (
      .iclk    (iclk),
      .i_rst   (i_rst),
      .i_push  (w_commit),
      .i_data  (FW'(w_commit_len)),
      .i_pop   (w_rd_fire && w_rd_last),
      .o_data  (w_fifo_q),
      .o_empty (w_fifo_em),
      .o_full  (w_fifo_full)
   );

   // write side: speculative pointer, commit or rewind at frame end
   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_cnt        <= '0;
         r_in_frame   <= 1'b0;
         r_accept     <= 1'b0;
         r_err        <= 1'b0;
         r_pend       <= 1'b0;
         r_pend_len   <= '0;
      end else begin
         r_pend     <= w_commit;
         r_pend_len <= PW'(w_commit_len);
         if (w_start) begin
            r_in_frame <= 1'b1;
            r_accept   <= !ofull;
            r_err      <= irx_er;
         end else if (w_end) begin
            r_in_frame <= 1'b0;
            r_err      <= 1'b0;
         end else if (w_in_data && irx_er) begin
            r_err <= 1'b1;
         end
         if (w_cnt_inc)    r_cnt <= w_cnt_base + CONE;
         else if (w_start) r_cnt <= '0;
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PONE;
         end else if (w_commit) begin
            r_wr_ptr     <= w_commit_wp;
            r_commit_ptr <= w_commit_wp;
         end else if (w_end) begin
            r_wr_ptr <= r_commit_ptr;
         end
      end
   end

   // read side: pointer, per-packet counter, last-byte flag, byte count
   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_ptr   <= '0;
         r_rd_cnt   <= '0;
         r_last     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_bytes    <= '0;
      end else begin
         r_last  <= w_rd_fire && w_rd_last;
         r_bytes <= r_bytes - PW'(w_rd_fire) +
                    (r_pend ? r_pend_len : '0);
         if (w_rd_fire) begin
            r_rd_ptr   <= r_rd_ptr + PONE;
            r_rd_valid <= 1'b1;
            r_rd_cnt   <= w_rd_last ? '0 : r_rd_cnt + FONE;
         end
      end
   end

   // byte RAM write port
   always_ff @(posedge iclk) begin
      if (w_wr_en) r_ram[r_wr_ptr[AW-1:0]] <= irx_d;
   end

   // byte RAM registered read port
   always_ff @(posedge iclk) begin
      if (w_rd_fire) r_rd_q <= r_ram[r_rd_ptr[AW-1:0]];
   end

endmodule

// File: tb/tb_copy_packet_to_memory.sv
// tb_copy_packet_to_memory: directed frames with a byte/length scoreboard.
// Expected bytes are queued when a frame should commit and popped on read.
module tb_copy_packet_to_memory;
   import copy_packet_pkg::*;

   localparam int DEPTH  = 2048;
   localparam int MINL   = 64;
   localparam int MAXL   = 1536;
   localparam int FDEPTH = 16;
`ifdef COPY_PACKET_STRIP_FCS_EN
   localparam int FCS = 4;
`else
   localparam int FCS = 0;
`endif

   logic        iclk = 1'b0;
   logic        i_rst = 1'b1;
   logic        idv = 1'b0;
   logic [7:0]  irx_d = '0;
   logic        irx_er = 1'b0;
   logic [2:0]  iframe_state = 3'd0;
   logic        ird_en = 1'b0;
   logic        oempty;
   logic        ofull;
   logic [7:0]  or_data;
   logic [10:0] olen_pac;
   logic        onext_last;
   logic [11:0] obytes_to_read;
   logic        ofifo_em;
   logic        ofifo_full;

   int          total = 0;
   int          bad = 0;
   int          model_used = 0;
   int          lens[$];
   logic [7:0]  exp_data[$];
   bit          exp_last[$];
   logic [7:0]  last_byte = '0;

   copy_packet_to_memory dut (
      .iclk           (iclk),
      .i_rst          (i_rst),
      .idv            (idv),
      .irx_d          (irx_d),
      .irx_er         (irx_er),
      .iframe_state   (iframe_state),
      .ird_en         (ird_en),
      .oempty         (oempty),
      .ofull          (ofull),
      .or_data        (or_data),
      .olen_pac       (olen_pac),
      .onext_last     (onext_last),
      .obytes_to_read (obytes_to_read),
      .ofifo_em       (ofifo_em),
      .ofifo_full     (ofifo_full)
   );

   always #5 iclk = ~iclk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_full();
      return ((DEPTH - model_used) < MAXL) || (lens.size() == FDEPTH);
   endfunction

   function automatic int head_len();
      return (lens.size() != 0) ? lens[0] : 0;
   endfunction

   task automatic check_status(input string tag);
      check({tag, "_bytes"}, 32'(obytes_to_read), model_used);
      check({tag, "_empty"}, 32'(oempty), 32'(model_used == 0));
      check({tag, "_fifo_em"}, 32'(ofifo_em), 32'(lens.size() == 0));
      check({tag, "_len_pac"}, 32'(olen_pac), head_len());
      check({tag, "_full"}, 32'(ofull), 32'(model_full()));
      check({tag, "_fifo_full"}, 32'(ofifo_full),
            32'(lens.size() == FDEPTH));
   endtask

   task automatic send_frame(input int len, input int err_at,
                             input bit ok_end);
      bit         acc;
      bit         good;
      int         n;
      logic [7:0] fr[$];
      logic [7:0] b;
      acc = !model_full();
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(0, 255));
         fr.push_back(b);
         iframe_state = ST_DATA;
         idv = 1'b1;
         irx_d = b;
         irx_er = (i == err_at);
         @(negedge iclk);
      end
      idv = 1'b0;
      irx_er = 1'b0;
      iframe_state = ok_end ? ST_END_OK : ST_END_ERR;
      @(negedge iclk);
      iframe_state = ST_IDLE;
      repeat (3) @(negedge iclk);
      good = ok_end && (err_at < 0) && (len >= MINL) &&
             (len <= MAXL) && acc;
      if (good) begin
         n = len - FCS;
         for (int j = 0; j < n; j++) begin
            exp_data.push_back(fr[j]);
            exp_last.push_back(j == n - 1);
         end
         lens.push_back(n);
         model_used += n;
      end
   endtask

   task automatic read_bytes(input int n);
      logic [7:0] b;
      bit         l;
      for (int k = 0; k <= n; k++) begin
         if (k > 0) begin
            b = exp_data.pop_front();
            l = exp_last.pop_front();
            model_used--;
            if (l) void'(lens.pop_front());
            last_byte = b;
            check("rd_data", 32'(or_data), 32'(b));
            check("rd_last", 32'(onext_last), 32'(l));
            check("rd_len_pac", 32'(olen_pac), head_len());
            check("rd_bytes", 32'(obytes_to_read), model_used);
         end
         ird_en = (k < n);
         @(negedge iclk);
      end
      check("rd_last_idle", 32'(onext_last), 32'd0);
   endtask

   task automatic clear_model();
      model_used = 0;
      lens.delete();
      exp_data.delete();
      exp_last.delete();
   endtask

   initial begin
      repeat (3) @(negedge iclk);
      i_rst = 1'b0;
      @(negedge iclk);
      check("rst_data", 32'(or_data), 32'd0);
      check("rst_last", 32'(onext_last), 32'd0);
      check_status("rst");

      send_frame(64, -1, 1'b1);
      check_status("f64");
      read_bytes(64 - FCS);
      check_status("f64_drained");

      send_frame(64, 10, 1'b1);
      check_status("err_frame");
      send_frame(100, -1, 1'b1);
      check_status("f100");
      read_bytes(model_used);

      send_frame(40, -1, 1'b1);
      check_status("short");
      send_frame(1600, -1, 1'b1);
      check_status("long");
      send_frame(64, -1, 1'b0);
      check_status("end_err");
      send_frame(64, -1, 1'b1);
      read_bytes(model_used);
      check_status("restored");

      send_frame(64, -1, 1'b1);
      send_frame(70, -1, 1'b1);
      check_status("b2b");
      read_bytes(model_used);
      check_status("b2b_drained");

      while (!model_full()) send_frame(64, -1, 1'b1);
      check_status("filled");
      send_frame(64, -1, 1'b1);
      check_status("fill_drop");
      read_bytes(head_len());
      check_status("fill_freed");
      send_frame(64, -1, 1'b1);
      check_status("fill_accept");
      read_bytes(model_used);
      check_status("fill_drained");

      ird_en = 1'b1;
      repeat (3) begin
         @(negedge iclk);
         check("empty_rd_hold", 32'(or_data), 32'(last_byte));
         check("empty_rd_last", 32'(onext_last), 32'd0);
         check("empty_rd_bytes", 32'(obytes_to_read), 32'd0);
      end
      ird_en = 1'b0;

      send_frame(64, -1, 1'b1);
      read_bytes(10);
      for (int i = 0; i < 20; i++) begin
         iframe_state = ST_DATA;
         idv = 1'b1;
         irx_d = 8'(i);
         @(negedge iclk);
      end
      i_rst = 1'b1;
      idv = 1'b0;
      iframe_state = ST_IDLE;
      repeat (2) @(negedge iclk);
      i_rst = 1'b0;
      clear_model();
      @(negedge iclk);
      check("rst2_data", 32'(or_data), 32'd0);
      check_status("rst2");
      send_frame(64, -1, 1'b1);
      check_status("post_rst");
      read_bytes(model_used);
      check_status("post_rst_drained");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
